morse_timing_config: RTL

Configuration store and BCD-to-binary converter for the Morse keyer timing. It holds the three user-editable unit durations (dit, dah, word gap) as `UNIT_BCD_W`-digit BCD values. It serves the currently selected value back to the menu and accepts its write strobes. A sequential converter turns each edited value into a binary tick count for the timing generator.

---
 rtl/morse_timing_config_if.sv | 24 ++
 rtl/morse_timing_config.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/morse_timing_config_if.sv
// Menu-side configuration bus for the Morse keyer timing store.
// The menu selects an index, reads back its BCD value and strobes in new values.
interface morse_timing_config_if #(
    parameter int UNIT_BCD_W = 6
);
    logic [2:0]              selected_index;
    logic [4*UNIT_BCD_W-1:0] selected_value;
    logic [4*UNIT_BCD_W-1:0] selected_new_value;
    logic                    selected_set;

    modport master (
        output selected_index,
        output selected_new_value,
        output selected_set,
        input  selected_value
    );

    modport slave (
        input  selected_index,
        input  selected_new_value,
        input  selected_set,
        output selected_value
    );
endinterface

// File: rtl/morse_timing_config.sv
// BCD configuration store for dit/dah/word durations with a digit-serial
// BCD-to-binary converter feeding the timing generator's tick counts.
module morse_timing_config #(
    parameter int                      UNIT_BCD_W   = 6,
    parameter int                      BIN_W        = 20,
    parameter logic [4*UNIT_BCD_W-1:0] DIT_DEFAULT  = 24'h000100,
    parameter logic [4*UNIT_BCD_W-1:0] DAH_DEFAULT  = 24'h000300,
    parameter logic [4*UNIT_BCD_W-1:0] WORD_DEFAULT = 24'h000700
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ce,
    morse_timing_config_if.slave        conf,
    output logic [BIN_W-1:0]            dit_ticks,
    output logic [BIN_W-1:0]            dah_ticks,
    output logic [BIN_W-1:0]            word_ticks,
    output logic                        ticks_valid,
    output logic                        busy
);
    localparam int DW    = 4 * UNIT_BCD_W;
    localparam int CNT_W = $clog2(UNIT_BCD_W + 1);

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    state_t           state, state_nxt;
    logic [DW-1:0]    cfg [3];
    logic [2:0]       dirty, dirty_nxt;
    logic [2:0]       we;
    logic             new_ok;
    logic [1:0]       sel, cur;
    logic [DW-1:0]    snap;
    logic [BIN_W-1:0] acc, acc_step;
    logic [CNT_W-1:0] cnt;
    logic             start;

    // A write is accepted only if every nibble is a legal BCD digit.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no latch is inferred.
        new_ok = 1'b1;
        for (int i = 0; i < UNIT_BCD_W; i++) begin
            if (conf.selected_new_value[4*i +: 4] > 4'd9) new_ok = 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            we[i] = ce && conf.selected_set && new_ok && (conf.selected_index == 3'(i));
        end
    end

    always_comb begin
        case (conf.selected_index)
            3'd0:    conf.selected_value = cfg[0];
            3'd1:    conf.selected_value = cfg[1];
            3'd2:    conf.selected_value = cfg[2];
            default: conf.selected_value = '0;
        endcase
    end

    always_comb begin
        if (dirty[0])      sel = 2'd0;
        else if (dirty[1]) sel = 2'd1;
        else               sel = 2'd2;
    end

    assign start = (state == IDLE) && (dirty != 3'b000);

    // The write strobe is applied after IDLE's clear so a same-edge write keeps the bit set.
    always_comb begin
        dirty_nxt = dirty;
        if (start) dirty_nxt[sel] = 1'b0;
        dirty_nxt = dirty_nxt | we;
    end

    assign acc_step = (acc << 3) + (acc << 1) + {{(BIN_W-4){1'b0}}, snap[DW-1 -: 4]};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (dirty != 3'b000) state_nxt = CONV;
            CONV:    if (cnt == '0) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n)  state <= IDLE;
        else if (ce) state <= state_nxt;
    end

    // cfg is reset like any other register because the defaults are its power-on contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg[0]     <= DIT_DEFAULT;
            cfg[1]     <= DAH_DEFAULT;
            cfg[2]     <= WORD_DEFAULT;
            dirty      <= 3'b111;
            cur        <= 2'd0;
            snap       <= '0;
            acc        <= '0;
            cnt        <= '0;
            dit_ticks  <= '0;
            dah_ticks  <= '0;
            word_ticks <= '0;
        end else if (ce) begin
            for (int i = 0; i < 3; i++) begin
                if (we[i]) cfg[i] <= conf.selected_new_value;
            end
            dirty <= dirty_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        cur  <= sel;
                        snap <= cfg[sel];
                        acc  <= '0;
                        cnt  <= CNT_W'(UNIT_BCD_W);
                    end
                end
                CONV: begin
                    if (cnt != '0) begin
                        acc  <= acc_step;
                        snap <= snap << 4;
                        cnt  <= cnt - CNT_W'(1);
                    end else begin
                        // All digits folded in; publish the result as the FSM enters COMMIT.
                        case (cur)
                            2'd0:    dit_ticks  <= acc;
                            2'd1:    dah_ticks  <= acc;
                            default: word_ticks <= acc;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    assign ticks_valid = (dirty == 3'b000) && (state == IDLE);
    assign busy        = (state != IDLE);

endmodule
